// File: rtl/dmem_arbiter_pkg.sv
// Shared word width, FSM encodings and the round-robin pick rule for the
// data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int WORD_W = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Returns the winning port id; on a tie the port not granted last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a registered-read data memory: one transaction
// at a time, IDLE -> ISSUE -> RESP, round-robin on simultaneous requests.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [WORD_W-1:0] p0_addr,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [WORD_W-1:0] p1_addr,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic              busy
);

  // Range limit widened to the full word so high address bits are never dropped.
  localparam logic [WORD_W-1:0] LIMIT = WORD_W'(SIZE);

  logic [1:0]        state_q;
  logic              last_q;
  logic              id_q;
  logic              we_q;
  logic              oor_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;

  logic              any_req;
  logic              win;
  logic              win_we;
  logic [WORD_W-1:0] win_addr;
  logic [WORD_W-1:0] win_wdata;
  logic              win_oor;

  assign any_req   = p0_req | p1_req;
  assign win       = rr_pick(p0_req, p1_req, last_q);
  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;
  assign win_oor   = (win_addr >= LIMIT);

  // Grant / latch stage: memory controls are registered so they are valid
  // for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q <= ST_ISSUE;
            last_q  <= win;
            id_q    <= win;
            we_q    <= win_we;
            oor_q   <= win_oor;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            rd_q    <= !win_we && !win_oor;
            wr_q    <= win_we && !win_oor;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_RESP;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = (state_q != ST_IDLE);

  // Response stage: a reset during RESP suppresses the completion pulse.
  logic              resp_ok;
  logic [WORD_W-1:0] rd_val;

  assign resp_ok  = (state_q == ST_RESP) && !reset;
  assign rd_val   = (!we_q && !oor_q) ? mem_read_data : '0;

  assign p0_done  = resp_ok && !id_q;
  assign p1_done  = resp_ok && id_q;
  assign p0_err   = p0_done && oor_q;
  assign p1_err   = p1_done && oor_q;
  assign p0_rdata = p0_done ? rd_val : '0;
  assign p1_rdata = p1_done ? rd_val : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic
// checked every cycle against a transaction-level model with a golden memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int SIZE = 1024;
  localparam int W    = WORD_W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         p0_req = 1'b0, p0_we = 1'b0;
  logic [W-1:0] p0_addr = '0, p0_wdata = '0;
  logic [W-1:0] p0_rdata;
  logic         p0_done, p0_err;
  logic         p1_req = 1'b0, p1_we = 1'b0;
  logic [W-1:0] p1_addr = '0, p1_wdata = '0;
  logic [W-1:0] p1_rdata;
  logic         p1_done, p1_err;
  logic         mem_read, mem_write, busy;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Attached data memory with registered read.
  logic [W-1:0] mem [SIZE];
  logic [W-1:0] mem_rd;
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    if (mem_read)  mem_rd <= mem[mem_address[9:0]];
  end
  assign mem_read_data = mem_rd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  // Transaction-level model: phase counts cycles since grant (0 = idle).
  int           ph = 0;
  bit           armed = 0;
  logic         m_last, m_id, m_we, m_oor;
  logic [W-1:0] m_addr, m_wdata;
  logic [W-1:0] gold [SIZE];
  bit           known [SIZE];
  bit           exp_done [2];

  task automatic model_step();
    if (reset) begin
      if (ph == 1 && m_we && !m_oor) begin
        gold[m_addr[9:0]] = m_wdata;
        known[m_addr[9:0]] = 1;
      end
      ph = 0; m_last = 1; m_id = 0; m_we = 0; m_oor = 0; m_addr = '0; m_wdata = '0;
      armed = 1;
    end else if (ph == 0) begin
      if (p0_req || p1_req) begin
        if (p0_req && p1_req) m_id = m_last ? 1'b0 : 1'b1;
        else                  m_id = p1_req;
        m_last  = m_id;
        m_we    = m_id ? p1_we : p0_we;
        m_addr  = m_id ? p1_addr : p0_addr;
        m_wdata = m_id ? p1_wdata : p0_wdata;
        m_oor   = (m_addr >= 64'(SIZE));
        ph = 1;
      end
    end else if (ph == 1) begin
      if (m_we && !m_oor) begin
        gold[m_addr[9:0]] = m_wdata;
        known[m_addr[9:0]] = 1;
      end
      ph = 2;
    end else begin
      ph = 0;
    end
  endtask

  task automatic compare();
    logic [W-1:0] r [2];
    bit skip [2];
    if (!armed) return;
    for (int p = 0; p < 2; p++) begin
      exp_done[p] = (ph == 2) && !reset && (m_id == p[0]);
      skip[p] = exp_done[p] && !m_we && !m_oor && !known[m_addr[9:0]];
      r[p] = (exp_done[p] && !m_we && !m_oor) ? gold[m_addr[9:0]] : '0;
    end
    chk("busy", W'(busy), W'(ph != 0));
    chk("mem_read", W'(mem_read), W'(ph == 1 && !m_we && !m_oor));
    chk("mem_write", W'(mem_write), W'(ph == 1 && m_we && !m_oor));
    chk("mem_address", mem_address, m_addr);
    chk("mem_write_data", mem_write_data, m_wdata);
    chk("p0_done", W'(p0_done), W'(exp_done[0]));
    chk("p1_done", W'(p1_done), W'(exp_done[1]));
    chk("p0_err", W'(p0_err), W'(exp_done[0] && m_oor));
    chk("p1_err", W'(p1_err), W'(exp_done[1] && m_oor));
    if (!skip[0]) chk("p0_rdata", p0_rdata, r[0]);
    if (!skip[1]) chk("p1_rdata", p1_rdata, r[1]);
  endtask

  task automatic cycle(input bit late_rst = 0);
    model_step();
    @(posedge clk);
    if (late_rst) begin
      #1 reset = 1'b1;
    end
    @(negedge clk);
    compare();
  endtask

  // Random requesters that follow the hold-until-done protocol.
  bit           act [2];
  bit           gap [2];
  logic         rwe [2];
  logic [W-1:0] rad [2];
  logic [W-1:0] rwd [2];

  function automatic logic [W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return W'(SIZE - 1);
      1:       return W'(SIZE);
      2:       return {32'($urandom_range(1, 255)), 32'($urandom)};
      default: return W'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic drive_random();
    if ($urandom_range(0, 49) == 0) begin
      reset = 1'b1;
      act[0] = 0; act[1] = 0;
    end else begin
      reset = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (act[p] && exp_done[p]) begin
          act[p] = 0; gap[p] = 1;
        end else if (!act[p]) begin
          if (gap[p]) gap[p] = 0;
          else if ($urandom_range(0, 2) == 0) begin
            act[p] = 1;
            rwe[p] = 1'($urandom_range(0, 1));
            rad[p] = rand_addr();
            rwd[p] = {32'($urandom), 32'($urandom)};
          end
        end
      end
    end
    p0_req = act[0]; p0_we = rwe[0]; p0_addr = rad[0]; p0_wdata = rwd[0];
    p1_req = act[1]; p1_we = rwe[1]; p1_addr = rad[1]; p1_wdata = rwd[1];
  endtask

  int order [$];

  initial begin
    for (int i = 0; i < SIZE; i++) known[i] = 0;
    rwe[0] = 0; rwe[1] = 0; rad[0] = '0; rad[1] = '0; rwd[0] = '0; rwd[1] = '0;

    // Reset state
    reset = 1'b1;
    cycle(); cycle();
    chk("rst_busy", W'(busy), '0);
    chk("rst_mem_read", W'(mem_read), '0);
    chk("rst_mem_address", mem_address, '0);
    chk("rst_p0_done", W'(p0_done), '0);
    reset = 1'b0;

    // Port 0 store 0xA5 to address 5
    p0_req = 1; p0_we = 1; p0_addr = 64'd5; p0_wdata = 64'hA5;
    cycle();
    chk("st_mem_write", W'(mem_write), 64'd1);
    chk("st_mem_address", mem_address, 64'd5);
    chk("st_mem_wdata", mem_write_data, 64'hA5);
    cycle();
    chk("st_p0_done", W'(p0_done), 64'd1);
    chk("st_p0_err", W'(p0_err), 64'd0);
    p0_req = 0; p0_we = 0;
    cycle();
    chk("st_idle_busy", W'(busy), 64'd0);

    // Port 0 load back from address 5
    p0_req = 1; p0_we = 0; p0_addr = 64'd5;
    cycle();
    chk("ld_mem_read", W'(mem_read), 64'd1);
    cycle();
    chk("ld_p0_done", W'(p0_done), 64'd1);
    chk("ld_p0_rdata", p0_rdata, 64'hA5);
    chk("ld_p1_done", W'(p1_done), 64'd0);
    p0_req = 0;
    cycle();

    // Port 1 load at SIZE: out of range
    p1_req = 1; p1_we = 0; p1_addr = 64'd1024;
    cycle();
    chk("oor_mem_read", W'(mem_read), 64'd0);
    cycle();
    chk("oor_p1_done", W'(p1_done), 64'd1);
    chk("oor_p1_err", W'(p1_err), 64'd1);
    chk("oor_p1_rdata", p1_rdata, 64'd0);
    p1_req = 0;
    cycle();

    // Port 1 load at a huge address whose low bits are 3
    p1_req = 1; p1_we = 0; p1_addr = 64'h1_0000_0003;
    cycle();
    chk("big_mem_read", W'(mem_read), 64'd0);
    cycle();
    chk("big_p1_err", W'(p1_err), 64'd1);
    chk("big_p1_rdata", p1_rdata, 64'd0);
    p1_req = 0;
    cycle();

    // Reset during RESP of a port 0 load
    p0_req = 1; p0_we = 0; p0_addr = 64'd5;
    cycle();
    cycle(1);
    chk("abort_p0_done", W'(p0_done), 64'd0);
    chk("abort_p0_rdata", p0_rdata, 64'd0);
    p0_req = 0;
    cycle();
    reset = 1'b0;
    chk("abort_busy", W'(busy), 64'd0);
    chk("abort_mem_address", mem_address, 64'd0);
    chk("abort_p0_done2", W'(p0_done), 64'd0);

    // Both ports held from the first cycle after reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 64'd5;
    p1_req = 1; p1_we = 0; p1_addr = 64'd5;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (p0_done) order.push_back(0);
      if (p1_done) order.push_back(1);
    end
    chk("rr_count", W'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) chk($sformatf("rr_order%0d", i), W'(order[i]), W'(i % 2));
    end
    p0_req = 0; p1_req = 0;
    cycle();

    // Randomized traffic
    act[0] = 0; act[1] = 0; gap[0] = 0; gap[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
